// File: rtl/pheap_pipe.sv
// pheap_pipe: pipelined binary min-heap for the PDES event scheduler.
// Holds up to 2^DEPTH-1 entries ordered by the CMP_WID LSBs of each entry; the
// minimum is always presented at out_data. One pipeline stage per heap level.
// Accepted ops: ENQ, DEQ and ENQ_DEQ (replace-min), at most one every 2 cycles.
// Optional build macro: PHEAP_ERR_FLAGS_EN adds sticky ovf/udf registers;
// without it ovf/udf are tied low (drop behaviour on full/empty is identical).
module pheap_pipe #(
  parameter int WIDTH   = 32,
  parameter int CMP_WID = 32,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] inp_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [DEPTH-1:0] elem_cnt,
  output logic             full,
  output logic             empty,
  output logic             ready,
  output logic             ovf,
  output logic             udf
);

  localparam int N  = (1 << DEPTH) - 1;
  localparam int IW = DEPTH;
  localparam int LW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] ROOT    = IW'(1);
  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW-1:0] CNT_MAX = IW'(N);

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ENQ = 2'b01,
    OP_DEQ = 2'b10,
    OP_RPL = 2'b11
  } op_t;

  // Heap slots, 1-based: children of slot i are 2i and 2i+1.
  logic [WIDTH-1:0] val_mem [1:N];
  logic             occ_q   [1:N];
  logic [IW-1:0]    free_q  [1:N];

  // Per-level slot write requests.
  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0] wr_occ;
  logic [IW-1:0]    wr_idx  [DEPTH];
  logic [WIDTH-1:0] wr_val  [DEPTH];
  logic [IW-1:0]    wr_free [DEPTH];

  // Op handed from level L-1 into the stage register of level L.
  op_t              pipe_op_d  [1:DEPTH-1];
  logic [WIDTH-1:0] pipe_val_d [1:DEPTH-1];
  logic [IW-1:0]    pipe_idx_d [1:DEPTH-1];

  logic [IW-1:0] elem_cnt_q, elem_cnt_d;
  logic          busy_q, busy_d;
  logic          accept;
  op_t           eff_op;

  function automatic logic [CMP_WID-1:0] key(input logic [WIDTH-1:0] v);
    return v[CMP_WID-1:0];
  endfunction

  // Free slots in the subtree rooted at a slot of the given index.
  function automatic logic [IW-1:0] free_init(input int slot);
    int lvl;
    lvl = 0;
    for (int k = 1; k < DEPTH; k++) begin
      if (slot >= (1 << k)) lvl = k;
    end
    return IW'((1 << (DEPTH - lvl)) - 1);
  endfunction

  assign ready     = rst_n & ~busy_q;
  assign empty     = (elem_cnt_q == '0);
  assign full      = (elem_cnt_q == CNT_MAX);
  assign out_valid = ~empty;
  assign elem_cnt  = elem_cnt_q;
  assign out_data  = occ_q[1] ? val_mem[1] : '0;

  // Issue: accept an op, turn boundary cases into drops/ENQ, update the count.
  always_comb begin
    accept = ready & (enq | deq);
    eff_op = OP_NOP;
    if (accept) begin
      case ({deq, enq})
        2'b01:   eff_op = full  ? OP_NOP : OP_ENQ;
        2'b10:   eff_op = empty ? OP_NOP : OP_DEQ;
        2'b11:   eff_op = empty ? OP_ENQ : OP_RPL;
        default: eff_op = OP_NOP;
      endcase
    end
    busy_d     = accept;
    elem_cnt_d = elem_cnt_q;
    case (eff_op)
      OP_ENQ:  elem_cnt_d = elem_cnt_q + ONE;
      OP_DEQ:  elem_cnt_d = elem_cnt_q - ONE;
      default: elem_cnt_d = elem_cnt_q;
    endcase
  end

  // Entry count and the one-idle-cycle spacing between accepted ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PHEAP_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky flags: ENQ on full sets ovf, DEQ or ENQ_DEQ on empty sets udf.
  always_comb begin
    ovf_d = ovf_q | (accept & enq & ~deq & full);
    udf_d = udf_q | (accept & deq & empty);
  end

  // Flags stay set until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      op_t              st_op;
      logic [WIDTH-1:0] st_val;
      logic [IW-1:0]    st_idx;
      logic             s_occ;
      logic [IW-1:0]    s_free;
      logic             w_en;
      logic             w_occ;
      logic [WIDTH-1:0] w_val;
      logic [IW-1:0]    w_free;

      if (gi == 0) begin : g_src
        assign st_op  = eff_op;
        assign st_val = inp_data;
        assign st_idx = ROOT;
      end else begin : g_src
        op_t              op_q;
        logic [WIDTH-1:0] val_q;
        logic [IW-1:0]    idx_q;

        // Capture the op handed down by the level above; reset cancels it.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            op_q  <= OP_NOP;
            idx_q <= ROOT;
          end else begin
            op_q  <= pipe_op_d[gi];
            idx_q <= pipe_idx_d[gi];
          end
        end

        // Carried value needs no reset: it is ignored while op_q is NOP.
        always_ff @(posedge clk) begin
          val_q <= pipe_val_d[gi];
        end

        assign st_op  = op_q;
        assign st_val = val_q;
        assign st_idx = idx_q;
      end

      assign s_occ  = occ_q[st_idx];
      assign s_free = free_q[st_idx];

      if (gi < DEPTH - 1) begin : g_body
        logic [WIDTH-1:0] s_val;
        logic [IW-1:0]    l_idx, r_idx, c_idx;
        logic [WIDTH-1:0] c_val;
        logic             c_occ, pick_r;
        op_t              f_op;
        logic [WIDTH-1:0] f_val;
        logic [IW-1:0]    f_idx;

        assign s_val = val_mem[st_idx];

        // Child to pull up or swap with: smaller occupied one, left on a tie.
        always_comb begin
          l_idx  = {st_idx[IW-2:0], 1'b0};
          r_idx  = {st_idx[IW-2:0], 1'b1};
          pick_r = occ_q[r_idx] &
                   (~occ_q[l_idx] | (key(val_mem[r_idx]) < key(val_mem[l_idx])));
          c_idx  = pick_r ? r_idx : l_idx;
          c_val  = pick_r ? val_mem[r_idx] : val_mem[l_idx];
          c_occ  = occ_q[l_idx] | occ_q[r_idx];
        end

        // Slot update at this level and the op forwarded to the next one.
        always_comb begin
          w_en   = 1'b0;
          w_occ  = s_occ;
          w_val  = s_val;
          w_free = s_free;
          f_op   = OP_NOP;
          f_val  = st_val;
          f_idx  = l_idx;
          case (st_op)
            OP_ENQ: begin
              w_en   = 1'b1;
              w_occ  = 1'b1;
              w_free = s_free - ONE;
              if (!s_occ) begin
                w_val = st_val;
              end else begin
                // Equal keys stay put; the larger value travels down.
                f_op  = OP_ENQ;
                f_idx = (free_q[l_idx] != '0) ? l_idx : r_idx;
                if (key(st_val) < key(s_val)) begin
                  w_val = st_val;
                  f_val = s_val;
                end
              end
            end
            OP_DEQ: begin
              w_en   = 1'b1;
              w_free = s_free + ONE;
              if (c_occ) begin
                w_val = c_val;
                f_op  = OP_DEQ;
                f_idx = c_idx;
              end else begin
                w_val = '0;
                w_occ = 1'b0;
              end
            end
            OP_RPL: begin
              // Sift the new value down; free counts do not change.
              w_en  = 1'b1;
              w_occ = 1'b1;
              if (c_occ && (key(c_val) < key(st_val))) begin
                w_val = c_val;
                f_op  = OP_RPL;
                f_idx = c_idx;
              end else begin
                w_val = st_val;
              end
            end
            default: ;
          endcase
        end

        assign pipe_op_d[gi+1]  = f_op;
        assign pipe_val_d[gi+1] = f_val;
        assign pipe_idx_d[gi+1] = f_idx;
      end else begin : g_body
        // Leaf level: nothing below, every op terminates here.
        always_comb begin
          w_en   = 1'b0;
          w_occ  = s_occ;
          w_val  = st_val;
          w_free = s_free;
          case (st_op)
            OP_ENQ: begin
              if (!s_occ) begin
                w_en   = 1'b1;
                w_occ  = 1'b1;
                w_free = s_free - ONE;
              end
            end
            OP_DEQ: begin
              w_en   = 1'b1;
              w_occ  = 1'b0;
              w_val  = '0;
              w_free = s_free + ONE;
            end
            OP_RPL: begin
              w_en  = 1'b1;
              w_occ = 1'b1;
            end
            default: ;
          endcase
        end
      end

      assign wr_en[gi]   = w_en;
      assign wr_occ[gi]  = w_occ;
      assign wr_idx[gi]  = st_idx;
      assign wr_val[gi]  = w_val;
      assign wr_free[gi] = w_free;
    end
  endgenerate

  // Occupancy and subtree free counts; reset empties the whole heap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= N; i++) begin
        occ_q[IW'(i)]  <= 1'b0;
        free_q[IW'(i)] <= free_init(i);
      end
    end else begin
      for (int l = 0; l < DEPTH; l++) begin
        if (wr_en[LW'(l)]) begin
          occ_q[wr_idx[LW'(l)]]  <= wr_occ[LW'(l)];
          free_q[wr_idx[LW'(l)]] <= wr_free[LW'(l)];
        end
      end
    end
  end

  // Slot values are not reset; occupancy decides whether they mean anything.
  always_ff @(posedge clk) begin
    for (int l = 0; l < DEPTH; l++) begin
      if (wr_en[LW'(l)]) val_mem[wr_idx[LW'(l)]] <= wr_val[LW'(l)];
    end
  end

endmodule

// File: tb/tb_pheap_pipe.sv
// Directed bench for pheap_pipe with a reference priority-queue model and a
// scoreboard of expected post-op state.
module tb_pheap_pipe;
  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int D   = 4;
  localparam int CAP = 15;

`ifdef PHEAP_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enq = 1'b0;
  logic         deq = 1'b0;
  logic [W-1:0] inp_data = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [D-1:0] elem_cnt;
  logic         full, empty, ready, ovf, udf;

  pheap_pipe #(.WIDTH(W), .CMP_WID(CW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .inp_data(inp_data),
    .out_data(out_data), .out_valid(out_valid), .elem_cnt(elem_cnt),
    .full(full), .empty(empty), .ready(ready), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] key;
    logic [D-1:0]  cnt;
    logic          valid;
    logic          full;
    logic          ovf;
    logic          udf;
  } exp_t;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] model[$];
  exp_t         sb[$];
  bit           exp_ovf = 1'b0;
  bit           exp_udf = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_idx();
    int mi = -1;
    foreach (model[i]) begin
      if (mi < 0 || model[i][CW-1:0] < model[mi][CW-1:0]) mi = i;
    end
    return mi;
  endfunction

  function automatic logic [CW-1:0] min_key();
    int mi = min_idx();
    logic [W-1:0] v;
    if (mi < 0) return '0;
    v = model[mi];
    return v[CW-1:0];
  endfunction

  task automatic wait_ready(input string tag);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, W'(ready), W'(1));
  endtask

  // One operation: model it, push expected state, apply, pop and compare.
  task automatic do_op(input logic e, input logic d, input logic [W-1:0] data, input string tag);
    exp_t x;
    int   mi;
    wait_ready(tag);
    enq = e; deq = d; inp_data = data;
    mi = min_idx();
    case ({d, e})
      2'b01: if (model.size() == CAP) exp_ovf = exp_ovf | FLAGS; else model.push_back(data);
      2'b10: if (mi < 0) exp_udf = exp_udf | FLAGS; else model.delete(mi);
      2'b11: begin
        if (mi < 0) exp_udf = exp_udf | FLAGS; else model.delete(mi);
        model.push_back(data);
      end
      default: ;
    endcase
    x.key   = min_key();
    x.cnt   = D'(model.size());
    x.valid = (model.size() != 0);
    x.full  = (model.size() == CAP);
    x.ovf   = exp_ovf;
    x.udf   = exp_udf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
    x = sb.pop_front();
    check({tag, "_key"},   W'(out_data[CW-1:0]), W'(x.key));
    check({tag, "_cnt"},   W'(elem_cnt),  W'(x.cnt));
    check({tag, "_valid"}, W'(out_valid), W'(x.valid));
    check({tag, "_full"},  W'(full),      W'(x.full));
    check({tag, "_ovf"},   W'(ovf),       W'(x.ovf));
    check({tag, "_udf"},   W'(udf),       W'(x.udf));
    $display("op %s enq=%0b deq=%0b data=%0h -> out_data=%0h elem_cnt=%0d", tag, e, d, data, out_data, elem_cnt);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; enq = 1'b0; deq = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_cnt"},   W'(elem_cnt),  W'(0));
    check({tag, "_valid"}, W'(out_valid), W'(0));
    check({tag, "_data"},  out_data,      W'(0));
    check({tag, "_rdy0"},  W'(ready),     W'(0));
    check({tag, "_empty"}, W'(empty),     W'(1));
    check({tag, "_full"},  W'(full),      W'(0));
    check({tag, "_ovf"},   W'(ovf),       W'(0));
    check({tag, "_udf"},   W'(udf),       W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_rdy1"}, W'(ready), W'(1));
    model.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    $display("reset %s done", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum_up;
    int xor_up;
    int vals[5];

    repeat (2) @(posedge clk);
    apply_reset("rst0");

    // Basic insert/remove ordering.
    vals = '{7, 3, 9, 1, 5};
    foreach (vals[i]) do_op(1'b1, 1'b0, W'(vals[i]), "basic_enq");
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b1, '0, "basic_deq");
    check("basic_empty", W'(empty), W'(1));

    // Fill to capacity, overflow, replace-min while full, drain.
    for (int k = 15; k >= 1; k--) do_op(1'b1, 1'b0, W'(k), "fill_enq");
    do_op(1'b1, 1'b0, W'(0), "fill_ovf");
    check("fill_root", out_data, W'(1));
    do_op(1'b1, 1'b1, W'(20), "fill_rpl");
    for (int k = 0; k < 15; k++) do_op(1'b0, 1'b1, '0, "fill_deq");

    // Replace-min in a small heap.
    do_op(1'b1, 1'b0, W'(10), "rpl_enq");
    do_op(1'b1, 1'b0, W'(20), "rpl_enq");
    do_op(1'b1, 1'b0, W'(30), "rpl_enq");
    do_op(1'b1, 1'b1, W'(25), "rpl_op");
    for (int k = 0; k < 3; k++) do_op(1'b0, 1'b1, '0, "rpl_deq");

    // Underflow and replace-min on empty.
    do_op(1'b0, 1'b1, '0, "udf_deq");
    do_op(1'b1, 1'b1, W'(4), "udf_rpl");
    do_op(1'b0, 1'b1, '0, "udf_drain");

    // enq held high: only every other cycle is accepted.
    wait_ready("hold");
    for (int k = 0; k < 6; k++) begin
      enq = 1'b1;
      inp_data = W'(100 + k);
      #1;
      check($sformatf("hold_ready%0d", k), W'(ready), W'((k % 2) == 0));
      $display("hold cycle %0d ready=%0b", k, ready);
      if ((k % 2) == 0) model.push_back(W'(100 + k));
      @(negedge clk);
    end
    enq = 1'b0;
    #1;
    check("hold_cnt", W'(elem_cnt), W'(model.size()));
    check("hold_min", W'(out_data[CW-1:0]), W'(min_key()));
    for (int k = 0; k < 3; k++) do_op(1'b0, 1'b1, '0, "hold_deq");

    // Duplicate keys with distinct upper bits.
    do_op(1'b1, 1'b0, 32'h000A_0005, "dup_enq");
    do_op(1'b1, 1'b0, 32'h000B_0005, "dup_enq");
    do_op(1'b1, 1'b0, 32'h000C_0005, "dup_enq");
    sum_up = 0;
    xor_up = 0;
    for (int k = 0; k < 3; k++) begin
      sum_up += int'(out_data[W-1:CW]);
      xor_up ^= int'(out_data[W-1:CW]);
      do_op(1'b0, 1'b1, '0, "dup_deq");
    end
    check("dup_sum", W'(sum_up), W'(33));
    check("dup_xor", W'(xor_up), W'(13));

    // Reset while an insert is still travelling down the levels.
    for (int k = 8; k >= 1; k--) do_op(1'b1, 1'b0, W'(10 * k), "mid_enq");
    apply_reset("rst_mid");
    do_op(1'b1, 1'b0, W'(2), "post_enq");
    check("post_root", out_data, W'(2));
    do_op(1'b1, 1'b0, W'(6), "post_enq");
    do_op(1'b0, 1'b1, '0, "post_deq");
    do_op(1'b0, 1'b1, '0, "post_deq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pheap_pipe.md
Name: pheap_pipe

Overview:
- Parametrised pipelined min-priority queue (binary heap) for the PDES event scheduler. Holds up to 2^DEPTH-1 entries, ordered by the CMP_WID LSBs of each entry. The minimum entry is always at out_data.
- Generalises the fixed 4-level heap to DEPTH levels with a generate loop. Adds replace-min (simultaneous enq+deq), out_valid, and overflow/underflow protection.

Parameters:
- WIDTH, 32, data width of entries.
- CMP_WID, 32, number of LSBs compared as key (CMP_WID <= WIDTH).
- DEPTH, 4, number of heap levels; capacity = 2^DEPTH-1 (15 at default); DEPTH >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- enq  in  1  insert inp_data; sampled only when ready=1.
- deq  in  1  remove out_data; sampled only when ready=1.
- inp_data  in  WIDTH  entry to insert.
- out_data  out  WIDTH  current minimum entry (root); 0 when empty.
- out_valid  out  1  root holds a valid entry (equals ~empty).
- elem_cnt  out  DEPTH  number of stored entries.
- full  out  1  elem_cnt == 2^DEPTH-1.
- empty  out  1  elem_cnt == 0.
- ready  out  1  may accept an operation this cycle.
- ovf  out  1  sticky overflow flag (see Optional Feature).
- udf  out  1  sticky underflow flag (see Optional Feature).

Behaviour:
- Storage: each level L has 2^L slots. Per slot: value, occupied bit, and free-count of its subtree (width DEPTH). Reset values: occupied=0, free = 2^(DEPTH-L)-1. Slot data registers are not reset.
- Reset: out_data=0, out_valid=0, elem_cnt=0, empty=1, full=0, ready=0 during reset and 1 in the first cycle after it, ovf=0, udf=0, all in-flight pipeline ops cleared to NOP.
- Issue rule: an operation is accepted when ready=1 and (enq|deq). ready=0 in the cycle after any accepted operation, so at most one operation per 2 cycles. This guarantees level L+1 has finished writing before level L reads its children.
- Operation encoding {deq,enq}: 00 NOP, 01 ENQ, 10 DEQ, 11 ENQ_DEQ (replace-min).
- Pipeline: one stage per level. Each stage carries op, value, and slot index to the next level. Stage L acts on the slot chosen by stage L-1.
- ENQ at a slot:
  - Slot empty: store the value; the op terminates.
  - Slot occupied: keep min(value, slot). Strict <, so an equal key does not displace. Forward the larger value as ENQ to the left child if left free>0, otherwise to the right child.
  - Decrement the slot's free count.
- DEQ at a slot:
  - Pull the smaller occupied child into the slot. On an equal key, pick left. Forward DEQ to that child and increment the slot's free count.
  - No occupied child: clear the slot (occupied=0, value=0) and terminate.
- ENQ_DEQ at root: place inp_data at the root, then sift down.
  - Compare with the smaller occupied child. If the child is smaller, swap and forward ENQ_DEQ to that child; else terminate.
  - Free counts are unchanged.
- Latency: out_data and elem_cnt reflect the accepted op on the next clock edge. Deeper levels settle DEPTH-1 cycles later. Correctness is guaranteed because of the 2-cycle issue rule.
- elem_cnt update: ENQ +1, DEQ -1, ENQ_DEQ unchanged. Never wraps.
- Boundaries:
  - ENQ when full: dropped, heap and count unchanged, ovf set.
  - DEQ when empty: dropped, udf set.
  - ENQ_DEQ when empty: executed as ENQ; udf set.
  - ENQ_DEQ when full: allowed.
  - Operations presented while ready=0: ignored, no flag.
- Reset mid-operation: all levels and in-flight ops are discarded. The heap is empty after reset.

Optional Feature:
- Macro PHEAP_ERR_FLAGS_EN.
- Defined: ovf and udf are sticky registers, set as in Behaviour and cleared only by reset.
- Undefined: ovf=udf=0 constantly, with no flag registers. Drop and clamp behaviour on full/empty is identical in both builds.

Test Plan:
- Reset, then ENQ 7, 3, 9, 1, 5 (one every 2 cycles) -> out_data 7, 3, 3, 1, 1 after each op; elem_cnt=5; then 5 DEQs -> out_data 3, 5, 7, 9, 0; empty=1, out_valid=0.
- DEPTH=4: fill with keys 15 down to 1 -> full=1, elem_cnt=15. 16th ENQ (0) -> dropped, out_data=1, ovf=1 when the macro is defined (0 when undefined).
- Hold 10, 20, 30; ENQ_DEQ 25 -> out_data=20, elem_cnt=3; DEQs return 20, 25, 30.
- Empty heap, DEQ -> udf=1, elem_cnt=0. ENQ_DEQ 4 -> out_data=4, elem_cnt=1.
- enq held high for 6 cycles -> ready toggles 1,0,1,0,1,0; exactly 3 entries inserted.
- Duplicate keys 5, 5, 5 with distinct upper bits -> three DEQs each return key 5; entry count is preserved.
- Assert rst_n=0 mid-sift after 8 ENQs -> next cycle elem_cnt=0, out_valid=0; a subsequent ENQ 2 gives out_data=2.
